// File: rtl/uart_tx_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_drain
//   Drains bytes from an upstream show-ahead FIFO and serialises each one as
//   an 8N1 UART frame: start bit, 8 data bits LSB first, stop bit. Frames run
//   back to back with no idle gap while the FIFO stays non-empty and i_en is
//   high.
//
//   Optional feature (macro UART_TX_DRAIN_PARITY_EN): when defined, an
//   even-parity bit is sent between the last data bit and the stop bit
//   (8E1, 11 bit times per frame). When undefined, frames are 8N1
//   (10 bit times) and no parity logic exists.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit time (2..65535)
//
// Ports
//   i_clk         clock; all state changes on the rising edge
//   i_reset_n     asynchronous active-low reset
//   i_en          drain enable; only looked at when a new byte could be popped
//   i_fifo_empty  upstream FIFO empty flag
//   i_data        upstream FIFO head byte, valid whenever i_fifo_empty = 0
//   o_rd          pop strobe, one cycle per byte, same cycle as the capture
//   o_tx          serial line, idle high
//   o_busy        high while a frame is on the line
//   o_frame_done  one-cycle pulse on the final cycle of the stop bit
//   o_dbg_state   current FSM state encoding, for observation only
//
// Handshake: the FIFO is show-ahead. A pop happens on any rising edge where
//   o_rd = 1; o_rd is only raised when i_fifo_empty = 0, and i_data is
//   captured on that same edge, so FIFO contents outside that edge never
//   reach the line.
// -----------------------------------------------------------------------------
module uart_tx_drain #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic       i_fifo_empty,
  input  logic [7:0] i_data,
  output logic       o_rd,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic [2:0] o_dbg_state
);

  localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_DRAIN_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q,  baud_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  // Low from reset until the first rising edge after release, so no pop can
  // occur in the cycle in which reset is released.
  logic          armed_q;

  logic baud_last;
  logic can_pop;

  assign baud_last = (baud_q == BAUD_LAST);
  assign can_pop   = armed_q & i_en & ~i_fifo_empty;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q + CW'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    o_rd         = 1'b0;
    o_tx         = 1'b1;
    o_frame_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (can_pop) begin
          o_rd    = 1'b1;
          shift_d = i_data;
          state_d = S_START;
        end
      end

      S_START: begin
        o_tx = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        o_tx = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          // Rotate rather than shift: after 8 bits the register holds the
          // original byte again, which the parity bit is computed from.
          shift_d = {shift_q[0], shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_DRAIN_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

`ifdef UART_TX_DRAIN_PARITY_EN
      S_PARITY: begin
        o_tx = ^shift_q;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        o_tx = 1'b1;
        if (baud_last) begin
          o_frame_done = 1'b1;
          baud_d       = '0;
          bit_d        = '0;
          // Chain straight into the next start bit when more data waits.
          if (can_pop) begin
            o_rd    = 1'b1;
            shift_d = i_data;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
module tb_uart_tx_drain;

  localparam int CPB = 4;
`ifdef UART_TX_DRAIN_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  // ---------------- clock / reset / DUT ----------------
  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_en;
  logic       i_fifo_empty;
  logic [7:0] i_data;
  logic       o_rd;
  logic       o_tx;
  logic       o_busy;
  logic       o_frame_done;
  logic [2:0] o_dbg_state;

  always #5 i_clk = ~i_clk;

  uart_tx_drain #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_en         (i_en),
    .i_fifo_empty (i_fifo_empty),
    .i_data       (i_data),
    .o_rd         (o_rd),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         pop_cnt = 0;
  int         pop_cyc[$];
  logic [7:0] fifo_q[$];      // upstream FIFO contents, head at index 0
  logic [0:0] exp_q[$];       // expected line level, one entry per cycle
  bit         armed = 1'b0;   // model: a pop is allowed in this cycle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Whole frame as seen on the line, one entry per clock.
  task automatic push_frame(input logic [7:0] b);
    for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < CPB; k++) exp_q.push_back(b[i]);
`ifdef UART_TX_DRAIN_PARITY_EN
    for (int k = 0; k < CPB; k++) exp_q.push_back(^b);
`endif
    for (int k = 0; k < CPB; k++) exp_q.push_back(1'b1);
  endtask

  // One clock: drive FIFO view at the negedge, check outputs, advance model.
  task automatic step();
    logic e_rd, e_tx, e_busy, e_done;
    i_fifo_empty = (fifo_q.size() == 0);
    i_data       = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
    #1;
    if (!i_reset_n) begin
      exp_q.delete();
      armed  = 1'b0;
      e_rd   = 1'b0;
      e_tx   = 1'b1;
      e_busy = 1'b0;
      e_done = 1'b0;
    end else begin
      e_tx   = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
      e_busy = (exp_q.size() != 0);
      e_done = (exp_q.size() == 1);
      e_rd   = armed && i_en && (fifo_q.size() != 0) && (exp_q.size() <= 1);
    end
    chk("o_rd", o_rd, e_rd);
    chk("o_tx", o_tx, e_tx);
    chk("o_busy", o_busy, e_busy);
    chk("o_frame_done", o_frame_done, e_done);
    @(posedge i_clk);
    if (i_reset_n) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (e_rd) begin
        push_frame(fifo_q.pop_front());
        pop_cnt++;
        pop_cyc.push_back(cyc);
      end
      armed = 1'b1;
    end
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    i_reset_n    = 1'b0;
    i_en         = 1'b0;
    i_fifo_empty = 1'b1;
    i_data       = 8'h00;
    @(negedge i_clk);

    // reset state
    chk("rst_state", o_dbg_state, 3'd0);
    run(3);
    i_reset_n = 1'b1;
    i_en      = 1'b1;

    // single byte 0xA5
    fifo_q.push_back(8'hA5);
    pop_cnt = 0;
    run(FRAME + 6);
    chk("a5_pops", pop_cnt, 1);
    chk("a5_idle_state", o_dbg_state, 3'd0);

    // back-to-back 0x01, 0x02, 0x03
    pop_cnt = 0;
    pop_cyc.delete();
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h03);
    run(3 * FRAME + 6);
    chk("b2b_pops", pop_cnt, 3);
    if (pop_cyc.size() == 3) begin
      chk("b2b_gap01", pop_cyc[1] - pop_cyc[0], FRAME);
      chk("b2b_gap12", pop_cyc[2] - pop_cyc[1], FRAME);
    end

    // empty FIFO for 100 cycles with enable high
    pop_cnt = 0;
    run(100);
    chk("empty_pops", pop_cnt, 0);

    // mid-frame disable with 2 bytes behind 0x3C
    pop_cnt = 0;
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    for (int k = 0; k < 8 && pop_cnt == 0; k++) step();
    chk("dis_first_pop", pop_cnt, 1);
    run(10);
    i_en = 1'b0;
    run(FRAME + 20);
    chk("dis_pops", pop_cnt, 1);
    chk("dis_fifo_left", fifo_q.size(), 2);

    // mid-frame reset during data bit 3
    pop_cnt = 0;
    i_en    = 1'b1;
    for (int k = 0; k < 8 && pop_cnt == 0; k++) step();
    chk("rst_first_pop", pop_cnt, 1);
    run(18);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("rst_async_tx", o_tx, 1'b1);
    chk("rst_async_busy", o_busy, 1'b0);
    chk("rst_async_rd", o_rd, 1'b0);
    @(negedge i_clk);
    run(2);
    i_reset_n = 1'b1;
    run(FRAME + 6);
    chk("rst_pops", pop_cnt, 2);
    chk("rst_fifo_left", fifo_q.size(), 0);

    // parity-relevant bytes 0x07 and 0x03
    fifo_q.push_back(8'h07);
    fifo_q.push_back(8'h03);
    run(2 * FRAME + 6);

    // random traffic and enable toggling
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0 && fifo_q.size() < 4) fifo_q.push_back(8'($urandom));
      if ($urandom_range(0, 29) == 0) i_en = ~i_en;
      step();
    end
    i_en = 1'b1;
    for (int k = 0; k < 6 * FRAME && (fifo_q.size() != 0 || exp_q.size() != 0); k++) step();
    chk("drain_fifo", fifo_q.size(), 0);
    chk("drain_idle", o_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 16, clocks per serial bit time (legal range 2..65535).
REQ-002 SHALL have port: i_clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_en  input  1  drain enable; sampled only when idle.
REQ-005 SHALL have port: i_fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port: i_data  input  8  upstream FIFO head byte; combinational, valid whenever i_fifo_empty=0.
REQ-007 SHALL have port: o_rd  output  1  upstream pop strobe, one cycle per byte.
REQ-008 SHALL have port: o_tx  output  1  serial line; idle high.
REQ-009 SHALL have port: o_busy  output  1  high while a frame is on the line.
REQ-010 SHALL have port: o_frame_done  output  1  one-cycle pulse on the last cycle of a stop bit.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is present only per REQ-027.
REQ-012 SHALL, in IDLE with i_en=1 and i_fifo_empty=0, assert o_rd for exactly that cycle, capture i_data into an 8-bit shift register on the same edge, and enter START.
REQ-013 SHALL never assert o_rd while i_fifo_empty=1 (no underflow) or in any state other than IDLE, except per REQ-019.
REQ-014 SHALL drive o_tx=0 for exactly CLKS_PER_BIT cycles in START, beginning the cycle after the o_rd pulse.
REQ-015 SHALL transmit 8 data bits LSB first in DATA, each held for exactly CLKS_PER_BIT cycles.
REQ-016 SHALL drive o_tx=1 for exactly CLKS_PER_BIT cycles in STOP.
REQ-017 SHALL use a baud counter of width ceil(log2(CLKS_PER_BIT)) and a 3-bit bit index; both clear on every state entry, and the baud counter wraps at CLKS_PER_BIT-1.
REQ-018 SHALL assert o_frame_done on the final STOP cycle only.
REQ-019 SHALL, on the final STOP cycle with i_en=1 and i_fifo_empty=0, pop the next byte (o_rd=1, capture) and enter START directly, giving back-to-back frames with zero idle cycles; otherwise it SHALL enter IDLE.
REQ-020 SHALL hold o_busy=1 in START, DATA, PARITY and STOP, and o_busy=0 in IDLE.
REQ-021 SHALL complete a frame in progress when i_en deasserts mid-frame, then stop popping.
REQ-022 SHALL ignore i_data and i_fifo_empty outside pop cycles; the byte on the line is the captured copy only.
REQ-023 SHALL drive o_tx=1 in IDLE.

Reset
REQ-024 SHALL, on i_reset_n=0, immediately (asynchronously) force state=IDLE, o_tx=1, o_rd=0, o_busy=0, o_frame_done=0, counters=0 and shift register=0.
REQ-025 SHALL abandon any frame in progress when reset is asserted, without popping and without any o_tx low glitch after reset asserts.
REQ-026 SHALL wait at least one rising edge after reset release before any pop.

Configuration
REQ-027 SHALL, with macro UART_TX_DRAIN_PARITY_EN defined, insert a PARITY state between DATA and STOP that drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving a frame of 11*CLKS_PER_BIT cycles.
REQ-028 SHALL, without UART_TX_DRAIN_PARITY_EN, go DATA->STOP directly, giving a frame of 10*CLKS_PER_BIT cycles, with no parity logic synthesized.

Verification
REQ-029 SHALL cover single byte, with CLKS_PER_BIT=4, no parity, FIFO holding 0xA5, i_en=1: one o_rd pulse, then o_tx = 0 / 1,0,1,0,0,1,0,1 / 1, each bit 4 cycles; o_frame_done at cycle 40 after the pop; back to IDLE.
REQ-030 SHALL cover back-to-back, with FIFO holding 0x01,0x02,0x03: exactly 3 o_rd pulses spaced 40 cycles apart, and o_tx never high between a stop bit and the next start bit.
REQ-031 SHALL cover empty FIFO, with i_fifo_empty=1 for 100 cycles: o_rd=0, o_tx=1 and o_busy=0 throughout.
REQ-032 SHALL cover mid-frame disable, with i_en dropped during DATA of byte 0x3C while the FIFO holds 2 more bytes: the frame completes correctly, there are no further o_rd pulses, and the FIFO keeps 2 bytes.
REQ-033 SHALL cover mid-frame reset, with i_reset_n pulsed low during bit 3: o_tx=1 and o_busy=0 in the same cycle; after release the next byte starts with a fresh START bit.
REQ-034 SHALL cover parity, with UART_TX_DRAIN_PARITY_EN defined and bytes 0x07 and 0x03: parity bit 1 for 0x07 and 0 for 0x03; frame length 44 cycles at CLKS_PER_BIT=4.
